tx_seq: RTL and testbench

TX_SEQ -- requirements
Module: tx_seq

---
 rtl/tx_seq_pkg.sv | 27 ++
 rtl/tx_seq_timer.sv | 26 ++
 rtl/tx_seq.sv | 192 +++++++++++++++++++
 tb/tb_tx_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_seq_pkg.sv
// rtl/tx_seq_pkg.sv - shared state type, default parameters and width helpers for tx_seq
package tx_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4,
        FINISH    = 3'd5
    } state_e;

    localparam int unsigned DEF_DATA_W         = 32;
    localparam int unsigned DEF_GAP_CYCLES     = 0;
    localparam int unsigned DEF_MSB_FIRST      = 0;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

    // Width of the byte-count field: must hold 0..NB inclusive.
    function automatic int unsigned cnt_width(input int unsigned data_w);
        return $clog2(data_w / 8 + 1);
    endfunction

    function automatic int unsigned bits_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tx_seq_timer.sv
// rtl/tx_seq_timer.sv - clearable saturating cycle counter with equality compare
module tx_seq_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] target,
    output logic         hit
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_q != {W{1'b1}}) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign hit = (count_q == target);

endmodule

// File: rtl/tx_seq.sv
// rtl/tx_seq.sv - byte sequencer feeding a UART transmitter; TX_SEQ_TIMEOUT_EN adds a handshake watchdog
module tx_seq
    import tx_seq_pkg::*;
#(
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int unsigned MSB_FIRST      = DEF_MSB_FIRST,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int unsigned NB            = DATA_W / 8,
    localparam int unsigned CNT_W         = cnt_width(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CNT_W-1:0]  nbytes,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

`ifdef TX_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int unsigned TMAX = (TO_EN && (TIMEOUT_CYCLES > GAP_CYCLES)) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned TW   = bits_for(TMAX);
    localparam logic [TW-1:0]    GAP_T = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`ifdef TX_SEQ_TIMEOUT_EN
    localparam logic [TW-1:0]    TO_T  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
`endif
    localparam logic [CNT_W-1:0] NB_C  = CNT_W'(NB);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  n_clamp;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, busy_q, done_q;
    logic [TW-1:0]     tmr_target;
    logic              tmr_hit, tmr_clear;
`ifdef TX_SEQ_TIMEOUT_EN
    logic              error_q, error_d;
`endif

    // Byte k of an n-byte transfer, counted from the end chosen by MSB_FIRST.
    function automatic logic [7:0] pick(input logic [DATA_W-1:0] w,
                                        input logic [CNT_W-1:0]  k,
                                        input logic [CNT_W-1:0]  n);
        logic [CNT_W-1:0] pos;
        pos = (MSB_FIRST != 0) ? (n - k - CNT_W'(1)) : k;
        return 8'(w >> {pos, 3'b000});
    endfunction

    assign n_clamp = (nbytes > NB_C) ? NB_C : nbytes;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        n_d       = n_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
`ifdef TX_SEQ_TIMEOUT_EN
        error_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d = data_in;
                    n_d    = n_clamp;
                    idx_d  = '0;
                    if (n_clamp == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d   = SEND;
                        tx_data_d = pick(data_in, '0, n_clamp);
                    end
                end
            end
            SEND: begin
                state_d = WAIT_ACK;
                idx_d   = idx_q + 1'b1;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
`ifdef TX_SEQ_TIMEOUT_EN
                else if (tmr_hit) begin
                    state_d = FINISH;
                    error_d = 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (idx_q < n_q) begin
                        if (GAP_CYCLES > 0) begin
                            state_d = GAP;
                        end else begin
                            state_d   = SEND;
                            tx_data_d = pick(data_q, idx_q, n_q);
                        end
                    end else begin
                        state_d = FINISH;
                    end
                end
`ifdef TX_SEQ_TIMEOUT_EN
                else if (tmr_hit) begin
                    state_d = FINISH;
                    error_d = 1'b1;
                end
`endif
            end
            GAP: begin
                if (tmr_hit) begin
                    state_d   = SEND;
                    tx_data_d = pick(data_q, idx_q, n_q);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One counter serves both the inter-byte gap and the handshake watchdog.
    assign tmr_clear = (state_d != state_q);
`ifdef TX_SEQ_TIMEOUT_EN
    assign tmr_target = (state_q == GAP) ? GAP_T : TO_T;
`else
    assign tmr_target = GAP_T;
`endif

    tx_seq_timer #(
        .W(TW)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .target (tmr_target),
        .hit    (tmr_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef TX_SEQ_TIMEOUT_EN
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= (state_d == SEND);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == FINISH);
`ifdef TX_SEQ_TIMEOUT_EN
            error_q    <= error_d;
`endif
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef TX_SEQ_TIMEOUT_EN
    assign error    = error_q;
`else
    assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_tx_seq.sv
// tb/tb_tx_seq.sv - scoreboard bench for tx_seq (LSB-first, MSB-first and gapped instances)
module tb_tx_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_s [3];
    logic [31:0] din    [3];
    logic [2:0] nb      [3];
    logic       tbusy   [3] = '{1'b0, 1'b0, 1'b0};
    logic       txs     [3];
    logic [7:0] txd     [3];
    logic       bsy     [3];
    logic       dn      [3];
    logic       er      [3];

    logic [7:0] exp_q [3][$];
    bit         uart_en [3];
    bit         exp_err [3];
    int         nstart [3], ndone [3], done_cyc [3], start_cyc [3], last_fall [3], bcnt [3];
    int         cyc = 0;
    int         npass = 0, nchk = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tx_seq #(
            .DATA_W        (32),
            .GAP_CYCLES    ((g == 2) ? 5 : 0),
            .MSB_FIRST     ((g == 1) ? 1 : 0),
            .TIMEOUT_CYCLES(20)
        ) dut (
            .clk     (clk),
            .reset   (reset),
            .start   (start_s[g]),
            .data_in (din[g]),
            .nbytes  (nb[g]),
            .tx_busy (tbusy[g]),
            .tx_start(txs[g]),
            .tx_data (txd[g]),
            .busy    (bsy[g]),
            .done    (dn[g]),
            .error   (er[g])
        );
    end

    function automatic logic [7:0] exp_byte(input logic [31:0] d, input int k, input int n, input bit msb);
        int p;
        p = msb ? (n - 1 - k) : k;
        return d[8*p +: 8];
    endfunction

    // Output monitor / scoreboard pop, then a UART model holding busy 10 cycles per byte.
    always @(negedge clk) begin : mon
        logic [7:0] e;
        for (int i = 0; i < 3; i++) begin
            if (txs[i] === 1'b1) begin
                nstart[i]++;
                start_cyc[i] = cyc;
                nchk++;
                if (exp_q[i].size() == 0) begin
                    $display("FAIL sb_extra_byte dut%0d: got %h, expected no byte", i, txd[i]);
                end else begin
                    e = exp_q[i].pop_front();
                    if (txd[i] !== e) $display("FAIL sb_byte dut%0d: got %h expected %h", i, txd[i], e);
                    else npass++;
                end
            end
            if (dn[i] === 1'b1) begin
                ndone[i]++;
                done_cyc[i] = cyc;
                nchk++;
                if (er[i] !== exp_err[i]) $display("FAIL done_error dut%0d: got %b expected %b", i, er[i], exp_err[i]);
                else npass++;
            end
            if (reset || !uart_en[i]) begin
                tbusy[i] = 1'b0;
                bcnt[i]  = 0;
            end else if (txs[i] === 1'b1) begin
                tbusy[i] = 1'b1;
                bcnt[i]  = 10;
            end else if (bcnt[i] > 0) begin
                bcnt[i]--;
                if (bcnt[i] == 0) begin
                    tbusy[i]     = 1'b0;
                    last_fall[i] = cyc;
                end
            end
        end
    end

    task automatic send(input int i, input logic [31:0] d, input logic [2:0] n, output int sc);
        int nn;
        nn = (n > 3'd4) ? 4 : int'(n);
        for (int k = 0; k < nn; k++) exp_q[i].push_back(exp_byte(d, k, nn, (i == 1)));
        @(negedge clk);
        din[i] = d; nb[i] = n; start_s[i] = 1'b1; sc = cyc;
        @(negedge clk);
        start_s[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int n0, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            if (ndone[i] > n0) begin ok = 1'b1; return; end
        end
    endtask

    task automatic wait_starts(input int i, input int target, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            if (nstart[i] >= target) begin ok = 1'b1; return; end
        end
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            nchk++;
            if ({txs[i], bsy[i], dn[i], er[i], txd[i]} !== 12'h0)
                $display("FAIL reset_outputs dut%0d: got %h expected 000", i, {txs[i], bsy[i], dn[i], er[i], txd[i]});
            else npass++;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_lsb_first;
        int s0, d0, sc; bit ok;
        s0 = nstart[0]; d0 = ndone[0];
        send(0, 32'hA1B2C3D4, 3'd4, sc);
        wait_done(0, d0, ok);
        nchk++; if (!ok) $display("FAIL lsb_done_wait: got timeout expected done"); else npass++;
        nchk++; if (done_cyc[0] !== last_fall[0] + 1) $display("FAIL lsb_done_latency: got %0d expected %0d", done_cyc[0], last_fall[0] + 1); else npass++;
        repeat (3) @(posedge clk);
        nchk++; if (nstart[0] - s0 !== 4) $display("FAIL lsb_starts: got %0d expected 4", nstart[0] - s0); else npass++;
        nchk++; if (ndone[0] - d0 !== 1) $display("FAIL lsb_done_count: got %0d expected 1", ndone[0] - d0); else npass++;
        nchk++; if (exp_q[0].size() !== 0) $display("FAIL lsb_sb_empty: got %0d expected 0", exp_q[0].size()); else npass++;
        nchk++; if (txd[0] !== 8'hA1) $display("FAIL lsb_tx_data_hold: got %h expected a1", txd[0]); else npass++;
    endtask

    task automatic test_msb_first;
        int s0, d0, sc; bit ok;
        s0 = nstart[1]; d0 = ndone[1];
        send(1, 32'h11223344, 3'd3, sc);
        wait_done(1, d0, ok);
        nchk++; if (!ok) $display("FAIL msb_done_wait: got timeout expected done"); else npass++;
        repeat (3) @(posedge clk);
        nchk++; if (nstart[1] - s0 !== 3) $display("FAIL msb_starts: got %0d expected 3", nstart[1] - s0); else npass++;
        nchk++; if (exp_q[1].size() !== 0) $display("FAIL msb_sb_empty: got %0d expected 0", exp_q[1].size()); else npass++;
    endtask

    task automatic test_nbytes_bounds;
        int s0, d0, sc; bit ok;
        s0 = nstart[0]; d0 = ndone[0];
        send(0, 32'hFFFFFFFF, 3'd0, sc);
        wait_done(0, d0, ok);
        nchk++; if (!ok) $display("FAIL zero_done_wait: got timeout expected done"); else npass++;
        nchk++; if (done_cyc[0] !== sc + 1) $display("FAIL zero_done_latency: got %0d expected %0d", done_cyc[0], sc + 1); else npass++;
        nchk++; if (nstart[0] !== s0) $display("FAIL zero_no_tx_start: got %0d expected 0", nstart[0] - s0); else npass++;
        s0 = nstart[0]; d0 = ndone[0];
        send(0, 32'h0BADCAFE, 3'd7, sc);
        wait_done(0, d0, ok);
        nchk++; if (!ok) $display("FAIL clamp_done_wait: got timeout expected done"); else npass++;
        repeat (3) @(posedge clk);
        nchk++; if (nstart[0] - s0 !== 4) $display("FAIL clamp_starts: got %0d expected 4", nstart[0] - s0); else npass++;
        nchk++; if (exp_q[0].size() !== 0) $display("FAIL clamp_sb_empty: got %0d expected 0", exp_q[0].size()); else npass++;
    endtask

    task automatic test_gap_and_ignore;
        int s0, d0, sc; bit ok;
        s0 = nstart[2]; d0 = ndone[2];
        send(2, 32'hCAFEF00D, 3'd4, sc);
        wait_starts(2, s0 + 2, ok);
        nchk++; if (!ok) $display("FAIL gap_second_byte_wait: got timeout expected tx_start"); else npass++;
        nchk++; if (start_cyc[2] - last_fall[2] - 1 !== 5) $display("FAIL gap_idle_cycles: got %0d expected 5", start_cyc[2] - last_fall[2] - 1); else npass++;
        @(negedge clk);
        din[2] = 32'h12345678; nb[2] = 3'd1; start_s[2] = 1'b1;
        @(negedge clk);
        start_s[2] = 1'b0;
        wait_done(2, d0, ok);
        nchk++; if (!ok) $display("FAIL gap_done_wait: got timeout expected done"); else npass++;
        repeat (3) @(posedge clk);
        nchk++; if (nstart[2] - s0 !== 4) $display("FAIL gap_starts: got %0d expected 4", nstart[2] - s0); else npass++;
        nchk++; if (ndone[2] - d0 !== 1) $display("FAIL gap_done_count: got %0d expected 1", ndone[2] - d0); else npass++;
        nchk++; if (exp_q[2].size() !== 0) $display("FAIL gap_sb_empty: got %0d expected 0", exp_q[2].size()); else npass++;
    endtask

    task automatic test_back_to_back;
        int d0;
        d0 = ndone[0];
        @(negedge clk);
        din[0] = 32'h0; nb[0] = 3'd0; start_s[0] = 1'b1;
        @(negedge clk); #1;
        nchk++; if (dn[0] !== 1'b1) $display("FAIL b2b_first_done: got %b expected 1", dn[0]); else npass++;
        @(negedge clk); #1;
        nchk++; if (dn[0] !== 1'b0) $display("FAIL b2b_finish_start_ignored: got %b expected 0", dn[0]); else npass++;
        @(negedge clk);
        start_s[0] = 1'b0;
        #1;
        nchk++; if (dn[0] !== 1'b1) $display("FAIL b2b_idle_start_taken: got %b expected 1", dn[0]); else npass++;
        repeat (3) @(posedge clk);
        nchk++; if (ndone[0] - d0 !== 2) $display("FAIL b2b_done_count: got %0d expected 2", ndone[0] - d0); else npass++;
    endtask

    task automatic test_reset_mid;
        int s0, d0, sc; bit ok;
        s0 = nstart[0]; d0 = ndone[0];
        send(0, 32'h55667788, 3'd4, sc);
        wait_starts(0, s0 + 2, ok);
        nchk++; if (!ok) $display("FAIL mid_second_byte_wait: got timeout expected tx_start"); else npass++;
        repeat (3) @(posedge clk);
        nchk++; if (bsy[0] !== 1'b1) $display("FAIL mid_busy_before_reset: got %b expected 1", bsy[0]); else npass++;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        nchk++;
        if ({txs[0], bsy[0], dn[0], er[0], txd[0]} !== 12'h0)
            $display("FAIL mid_async_clear: got %h expected 000", {txs[0], bsy[0], dn[0], er[0], txd[0]});
        else npass++;
        exp_q[0].delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        nchk++; if (ndone[0] !== d0) $display("FAIL mid_no_done: got %0d expected 0", ndone[0] - d0); else npass++;
        s0 = nstart[0];
        send(0, 32'h99AABBCC, 3'd2, sc);
        wait_done(0, d0, ok);
        nchk++; if (!ok) $display("FAIL mid_restart_done_wait: got timeout expected done"); else npass++;
        repeat (3) @(posedge clk);
        nchk++; if (nstart[0] - s0 !== 2) $display("FAIL mid_restart_starts: got %0d expected 2", nstart[0] - s0); else npass++;
        nchk++; if (exp_q[0].size() !== 0) $display("FAIL mid_restart_sb_empty: got %0d expected 0", exp_q[0].size()); else npass++;
    endtask

`ifdef TX_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int s0, d0, sc; bit ok;
        uart_en[0] = 1'b0; exp_err[0] = 1'b1;
        s0 = nstart[0]; d0 = ndone[0];
        send(0, 32'hDEADBEEF, 3'd4, sc);
        wait_done(0, d0, ok);
        nchk++; if (!ok) $display("FAIL to_done_wait: got timeout expected done"); else npass++;
        nchk++; if (done_cyc[0] !== start_cyc[0] + 21) $display("FAIL to_latency: got %0d expected %0d", done_cyc[0], start_cyc[0] + 21); else npass++;
        nchk++; if (nstart[0] - s0 !== 1) $display("FAIL to_starts: got %0d expected 1", nstart[0] - s0); else npass++;
        nchk++; if (exp_q[0].size() !== 3) $display("FAIL to_dropped_bytes: got %0d expected 3", exp_q[0].size()); else npass++;
        exp_q[0].delete();
        @(negedge clk); #1;
        nchk++; if ({bsy[0], dn[0], er[0]} !== 3'b000) $display("FAIL to_back_to_idle: got %b expected 000", {bsy[0], dn[0], er[0]}); else npass++;
        uart_en[0] = 1'b1; exp_err[0] = 1'b0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0; din[i] = '0; nb[i] = '0;
            uart_en[i] = 1'b1; exp_err[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        test_reset;
        test_lsb_first;
        test_msb_first;
        test_nbytes_bounds;
        test_gap_and_ignore;
        test_back_to_back;
        test_reset_mid;
`ifdef TX_SEQ_TIMEOUT_EN
        test_timeout;
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
